// File: rtl/trace_cmd_if.sv
// trace_cmd_if
// Bundles the two handshakes around the trace command sequencer:
//   record side : in_valid, in_code, in_addr  -> sequencer ; in_ready <- sequencer
//   command side: out_valid, out_cmd, out_tag, out_index, out_offset, out_icache
//                 -> cache ; out_ready <- cache
// Modports:
//   master : the environment (trace source and cache consumer)
//   slave  : the sequencer itself
interface trace_cmd_if #(
   parameter int ADDR_W      = 32,
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 6
);
   localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;

   logic                   in_valid;
   logic [3:0]             in_code;
   logic [ADDR_W-1:0]      in_addr;
   logic                   in_ready;

   logic                   out_valid;
   logic                   out_ready;
   logic [2:0]             out_cmd;
   logic [TAG_W-1:0]       out_tag;
   logic [INDEX_BITS-1:0]  out_index;
   logic [OFFSET_BITS-1:0] out_offset;
   logic                   out_icache;

   modport master (
      output in_valid, in_code, in_addr, out_ready,
      input  in_ready, out_valid, out_cmd, out_tag, out_index, out_offset, out_icache
   );

   modport slave (
      input  in_valid, in_code, in_addr, out_ready,
      output in_ready, out_valid, out_cmd, out_tag, out_index, out_offset, out_icache
   );
endinterface

// File: rtl/trace_cmd_sequencer.sv
// trace_cmd_sequencer
// Decodes raw trace records (4-bit code + address) into L1 cache commands,
// splits the address into tag/index/offset and queues the result in an
// in-order FIFO that the cache drains with backpressure. Invalid codes are
// accepted, dropped and counted.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset (flushes the FIFO and counters)
//   bus        : trace_cmd_if.slave, record input and command output handshakes
//   rec_count  : records accepted (valid or not), wraps at 2^32
//   bad_count  : invalid records dropped, saturates at 0xFFFF
module trace_cmd_sequencer #(
   parameter int DEPTH       = 4,
   parameter int ADDR_W      = 32,
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   trace_cmd_if.slave          bus,
   output logic [31:0]         rec_count,
   output logic [15:0]         bad_count
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int SPLIT   = INDEX_BITS + OFFSET_BITS;
   // Entry layout: {icache, cmd[2:0], addr}
   localparam int ENTRY_W = ADDR_W + 4;

   localparam logic [2:0] CMD_READ       = 3'd0;
   localparam logic [2:0] CMD_WRITE      = 3'd1;
   localparam logic [2:0] CMD_I_FETCH    = 3'd2;
   localparam logic [2:0] CMD_L2_INVAL   = 3'd3;
   localparam logic [2:0] CMD_L2_DATA_RQ = 3'd4;
   localparam logic [2:0] CMD_CLR        = 3'd5;
   localparam logic [2:0] CMD_PRINT      = 3'd6;

   // Returns {code_is_valid, cmd}; invalid codes map to READ with valid=0.
   function automatic logic [3:0] decode_code(input logic [3:0] code);
      logic [3:0] res;
      case (code)
         4'd0:    res = {1'b1, CMD_READ};
         4'd1:    res = {1'b1, CMD_WRITE};
         4'd2:    res = {1'b1, CMD_I_FETCH};
         4'd3:    res = {1'b1, CMD_L2_INVAL};
         4'd4:    res = {1'b1, CMD_L2_DATA_RQ};
         4'd8:    res = {1'b1, CMD_CLR};
         4'd9:    res = {1'b1, CMD_PRINT};
         default: res = {1'b0, CMD_READ};
      endcase
      return res;
   endfunction

   logic [ENTRY_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [31:0]        rec_count_r;
   logic [15:0]        bad_count_r;

   logic [3:0]         dec_s;
   logic               code_ok_s;
   logic               accept_s;
   logic               push_s;
   logic               pop_s;
   logic [CNT_W-1:0]   count_nxt_s;
   logic [ENTRY_W-1:0] wr_entry_s;
   logic [ENTRY_W-1:0] head_s;

   // Handshake qualification, decode and next occupancy.
   always_comb begin
      dec_s       = decode_code(bus.in_code);
      code_ok_s   = dec_s[3];
      accept_s    = bus.in_valid && in_ready_r;
      push_s      = accept_s && code_ok_s;
      pop_s       = out_valid_r && bus.out_ready;
      wr_entry_s  = {(dec_s[2:0] == CMD_I_FETCH), dec_s[2:0], bus.in_addr};
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO control state and counters; ready/valid flags are registered from
   // the next occupancy so in_ready never sees out_ready combinationally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         rec_count_r <= 32'd0;
         bad_count_r <= 16'd0;
      end else begin
         count_r     <= count_nxt_s;
         in_ready_r  <= (count_nxt_s < CNT_W'(DEPTH));
         out_valid_r <= (count_nxt_s != CNT_W'(0));
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         if (accept_s) begin
            rec_count_r <= rec_count_r + 32'd1;
         end
         if (accept_s && !code_ok_s && (bad_count_r != 16'hFFFF)) begin
            bad_count_r <= bad_count_r + 16'd1;
         end
      end
   end

   // Entry storage; stale slots are harmless because pointers/count are reset.
   always_ff @(posedge clk) begin
      if (rst_n && push_s) begin
         mem_r[wr_ptr_r] <= wr_entry_s;
      end
   end

   // Head presentation, forced to zero while the FIFO is empty.
   always_comb begin
      head_s = mem_r[rd_ptr_r];
      if (out_valid_r) begin
         bus.out_icache = head_s[ENTRY_W-1];
         bus.out_cmd    = head_s[ENTRY_W-2:ADDR_W];
         bus.out_tag    = head_s[ADDR_W-1:SPLIT];
         bus.out_index  = head_s[SPLIT-1:OFFSET_BITS];
         bus.out_offset = head_s[OFFSET_BITS-1:0];
      end else begin
         bus.out_icache = 1'b0;
         bus.out_cmd    = 3'd0;
         bus.out_tag    = '0;
         bus.out_index  = '0;
         bus.out_offset = '0;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign rec_count     = rec_count_r;
   assign bad_count     = bad_count_r;
endmodule
